operand_fetch_stage: RTL and testbench

//  Register-read (ID->EX) stage of the pipelined rv32i core; the reading client of Regfile.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/operand_fetch_stage_if.sv | 41 ++++
 rtl/operand_forward_mux.sv | 30 +++
 rtl/operand_fetch_stage.sv | 74 +++++++
 tb/tb_operand_fetch_stage.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, forwarding-source enum and the ID/EX register layout
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;
    typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_e;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        logic [CTRL_W-1:0]     ctrl;
        logic [XLEN-1:0]       rs1_value;
        logic [XLEN-1:0]       rs2_value;
    } idex_t;
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: decode-slot inputs, regfile read port, EX/MEM/WB producer
// taps and the ID/EX register outputs of the operand fetch stage.
// master drives decode/regfile/producer signals; slave (the stage) drives addresses,
// stallOut, the out* register and stallCount.
interface operand_fetch_stage_if;
    import riscv_pkg::*;
    logic                  inValid;
    logic [REG_ADDR_W-1:0] inRs1, inRs2, inRd;
    logic                  inUsesRs1, inUsesRs2, inRegWrite, inIsLoad;
    logic [XLEN-1:0]       inPc, inImm;
    logic [CTRL_W-1:0]     inCtrl;
    logic                  flush;
    logic [REG_ADDR_W-1:0] addressForReading1, addressForReading2;
    logic [XLEN-1:0]       value1, value2;
    logic [XLEN-1:0]       exResult;
    logic [REG_ADDR_W-1:0] memRd, wbRd;
    logic                  memRegWrite, memValid, wbRegWrite;
    logic [XLEN-1:0]       memValue, wbValue;
    logic                  stallOut;
    logic                  outValid, outRegWrite, outIsLoad;
    logic [REG_ADDR_W-1:0] outRd;
    logic [XLEN-1:0]       outPc, outImm, outRs1Value, outRs2Value;
    logic [CTRL_W-1:0]     outCtrl;
    logic [31:0]           stallCount;
    modport master (
        output inValid, inRs1, inRs2, inRd, inUsesRs1, inUsesRs2, inRegWrite, inIsLoad,
               inPc, inImm, inCtrl, flush, value1, value2, exResult, memRd, memRegWrite,
               memValid, memValue, wbRd, wbRegWrite, wbValue,
        input  addressForReading1, addressForReading2, stallOut, outValid, outRd,
               outRegWrite, outIsLoad, outPc, outImm, outCtrl, outRs1Value, outRs2Value,
               stallCount
    );
    modport slave (
        input  inValid, inRs1, inRs2, inRd, inUsesRs1, inUsesRs2, inRegWrite, inIsLoad,
               inPc, inImm, inCtrl, flush, value1, value2, exResult, memRd, memRegWrite,
               memValid, memValue, wbRd, wbRegWrite, wbValue,
        output addressForReading1, addressForReading2, stallOut, outValid, outRd,
               outRegWrite, outIsLoad, outPc, outImm, outCtrl, outRs1Value, outRs2Value,
               stallCount
    );
endinterface

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: picks one operand from EX, MEM, WB or the regfile read data.
// idx: source register index; *_en/*_rd/*_value: producer taps; rf_value: regfile data;
// value: resolved operand (x0 always reads as zero).
module operand_forward_mux
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic                  ex_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_value,
    input  logic                  mem_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_value,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_value,
    input  logic [XLEN-1:0]       rf_value,
    output logic [XLEN-1:0]       value
);
    fwd_sel_e sel;
    always_comb begin
        sel = (ex_en && ex_rd == idx)   ? FWD_EX  :
              (mem_en && mem_rd == idx) ? FWD_MEM :
              (wb_en && wb_rd == idx)   ? FWD_WB  : FWD_RF;
        value = (idx == '0)       ? '0        :
                (sel == FWD_EX)   ? ex_value  :
                (sel == FWD_MEM)  ? mem_value :
                (sel == FWD_WB)   ? wb_value  : rf_value;
    end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register-read stage with EX/MEM/WB forwarding and load-use stall.
// clock/reset: rising-edge clock, synchronous active-high reset; bus: all stage signals.
module operand_fetch_stage
    import riscv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);
    idex_t           idex_q, idex_d;
    logic [31:0]     stall_count_q, stall_count_d;
    logic            hazard, stall, ex_en, mem_en;
    logic [XLEN-1:0] rs1_value, rs2_value;

    assign ex_en  = idex_q.valid & idex_q.reg_write;
    assign mem_en = bus.memValid & bus.memRegWrite;

    operand_forward_mux u_fwd1 (
        .idx(bus.inRs1), .ex_en(ex_en), .ex_rd(idex_q.rd), .ex_value(bus.exResult),
        .mem_en(mem_en), .mem_rd(bus.memRd), .mem_value(bus.memValue),
        .wb_en(bus.wbRegWrite), .wb_rd(bus.wbRd), .wb_value(bus.wbValue),
        .rf_value(bus.value1), .value(rs1_value)
    );
    operand_forward_mux u_fwd2 (
        .idx(bus.inRs2), .ex_en(ex_en), .ex_rd(idex_q.rd), .ex_value(bus.exResult),
        .mem_en(mem_en), .mem_rd(bus.memRd), .mem_value(bus.memValue),
        .wb_en(bus.wbRegWrite), .wb_rd(bus.wbRd), .wb_value(bus.wbValue),
        .rf_value(bus.value2), .value(rs2_value)
    );

    always_comb begin
        hazard = bus.inValid & idex_q.valid & idex_q.is_load & idex_q.reg_write
               & (idex_q.rd != '0)
               & ((bus.inUsesRs1 & (bus.inRs1 == idex_q.rd))
                | (bus.inUsesRs2 & (bus.inRs2 == idex_q.rd)));
        stall = hazard & ~bus.flush & ~reset;
        idex_d           = '0;
        idex_d.valid     = bus.inValid & ~bus.flush & ~stall;
        // Bubbles carry no write/load so nothing downstream forwards from them.
        idex_d.rd        = bus.inRd;
        idex_d.reg_write = idex_d.valid & bus.inRegWrite;
        idex_d.is_load   = idex_d.valid & bus.inIsLoad;
        idex_d.pc        = bus.inPc;
        idex_d.imm       = bus.inImm;
        idex_d.ctrl      = bus.inCtrl;
        idex_d.rs1_value = rs1_value;
        idex_d.rs2_value = rs2_value;
        stall_count_d    = stall_count_q + 32'(stall);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q        <= '0;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.addressForReading1 = bus.inRs1;
    assign bus.addressForReading2 = bus.inRs2;
    assign bus.stallOut           = stall;
    assign bus.outValid           = idex_q.valid;
    assign bus.outRd              = idex_q.rd;
    assign bus.outRegWrite        = idex_q.reg_write;
    assign bus.outIsLoad          = idex_q.is_load;
    assign bus.outPc              = idex_q.pc;
    assign bus.outImm             = idex_q.imm;
    assign bus.outCtrl            = idex_q.ctrl;
    assign bus.outRs1Value        = idex_q.rs1_value;
    assign bus.outRs2Value        = idex_q.rs2_value;
    assign bus.stallCount         = stall_count_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed scoreboard bench for operand_fetch_stage
module tb_operand_fetch_stage;
    typedef struct {
        logic        full;
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rf [32];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    operand_fetch_stage_if bus ();
    operand_fetch_stage dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    assign bus.value1 = rf[bus.addressForReading1];
    assign bus.value2 = rf[bus.addressForReading2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic [31:0] pc);
        bus.inValid = v; bus.inRs1 = rs1; bus.inRs2 = rs2;
        bus.inUsesRs1 = u1; bus.inUsesRs2 = u2; bus.inRd = rd;
        bus.inRegWrite = rw; bus.inIsLoad = ld;
        bus.inPc = pc; bus.inImm = pc ^ 32'h5A5A_0000; bus.inCtrl = pc[15:0] + 16'h1234;
    endtask

    task automatic push(input logic full, input logic valid, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic [31:0] pc,
                        input logic [31:0] rs1v, input logic [31:0] rs2v);
        exp_t e;
        e.full = full; e.valid = valid; e.rd = rd; e.rw = rw; e.ld = ld; e.pc = pc;
        e.imm  = (pc == 0) ? 32'h0 : pc ^ 32'h5A5A_0000;
        e.ctrl = (pc == 0) ? 16'h0 : pc[15:0] + 16'h1234;
        e.rs1v = rs1v; e.rs2v = rs2v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("outValid", 32'(bus.outValid), 32'(e.valid));
        check("outRegWrite", 32'(bus.outRegWrite), 32'(e.rw));
        check("outIsLoad", 32'(bus.outIsLoad), 32'(e.ld));
        if (e.full) begin
            check("outRd", 32'(bus.outRd), 32'(e.rd));
            check("outPc", bus.outPc, e.pc);
            check("outImm", bus.outImm, e.imm);
            check("outCtrl", 32'(bus.outCtrl), 32'(e.ctrl));
            check("outRs1Value", bus.outRs1Value, e.rs1v);
            check("outRs2Value", bus.outRs2Value, e.rs2v);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5] = 32'd15;
        reset = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 0; bus.exResult = 0;
        bus.memRd = 0; bus.memRegWrite = 0; bus.memValid = 0; bus.memValue = 0;
        bus.wbRd = 0; bus.wbRegWrite = 0; bus.wbValue = 0;
        push(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("reset_stallCount", bus.stallCount, 0);
        check("reset_stallOut", 32'(bus.stallOut), 0);
        reset = 1'b0;
        issue(1, 5, 0, 1, 1, 3, 1, 0, 32'h100);
        push(1, 1, 3, 1, 0, 32'h100, 32'd15, 32'd0);
        tick();
        bus.exResult = 32'h77;
        bus.memValid = 1; bus.memRegWrite = 1; bus.memRd = 3; bus.memValue = 32'h11;
        issue(1, 3, 3, 1, 1, 8, 1, 0, 32'h104);
        push(1, 1, 8, 1, 0, 32'h104, 32'h77, 32'h77);
        tick();
        bus.exResult = 32'h55; bus.memRd = 6;
        bus.wbRegWrite = 1; bus.wbRd = 7; bus.wbValue = 32'hAB;
        issue(1, 6, 7, 1, 1, 4, 1, 1, 32'h108);
        push(1, 1, 4, 1, 1, 32'h108, 32'h11, 32'hAB);
        tick();
        bus.memValid = 0; bus.wbRegWrite = 0;
        issue(1, 4, 0, 1, 0, 9, 1, 0, 32'h10C);
        #1;
        check("loaduse_stallOut", 32'(bus.stallOut), 1);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("loaduse_stallCount", bus.stallCount, 1);
        bus.memValid = 1; bus.memRd = 4; bus.memValue = 32'h44;
        issue(1, 4, 0, 1, 0, 0, 1, 1, 32'h10C);
        #1;
        check("held_stallOut", 32'(bus.stallOut), 0);
        push(1, 1, 0, 1, 1, 32'h10C, 32'h44, 32'h0);
        tick();
        bus.memValid = 0; bus.exResult = 32'hFF;
        issue(1, 0, 0, 1, 1, 4, 1, 1, 32'h110);
        #1;
        check("x0_stallOut", 32'(bus.stallOut), 0);
        push(1, 1, 4, 1, 1, 32'h110, 32'h0, 32'h0);
        tick();
        bus.exResult = 32'h99;
        issue(1, 4, 0, 0, 0, 4, 1, 1, 32'h114);
        #1;
        check("nouse_stallOut", 32'(bus.stallOut), 0);
        push(1, 1, 4, 1, 1, 32'h114, 32'h99, 32'h0);
        tick();
        bus.flush = 1;
        issue(1, 4, 0, 1, 0, 5, 1, 0, 32'h118);
        #1;
        check("flush_stallOut", 32'(bus.stallOut), 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("flush_stallCount", bus.stallCount, 1);
        bus.flush = 0;
        issue(1, 0, 0, 0, 0, 2, 1, 1, 32'h11C);
        push(1, 1, 2, 1, 1, 32'h11C, 32'h0, 32'h0);
        tick();
        issue(1, 0, 2, 0, 1, 6, 1, 0, 32'h120);
        #1;
        check("rs2_stallOut", 32'(bus.stallOut), 1);
        reset = 1'b1;
        #1;
        check("reset_mid_stallOut", 32'(bus.stallOut), 0);
        push(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("reset_mid_stallCount", bus.stallCount, 0);
        reset = 1'b0;
        issue(0, 5, 0, 1, 0, 3, 1, 1, 32'h124);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("bubble_stallCount", bus.stallCount, 0);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
